// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: generates BCLK/LRCLK from the system clock, captures
// the 16 MSBs of the left channel each frame and buffers them in a small FIFO.
module i2s_mic_rx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  input  logic        i2s_sd,
  output logic [15:0] pcm_out,
  output logic        audio_valid,
  input  logic        sample_ack,
  output logic        overflow
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Bit clock generation and slot tracking
  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       slot_q, slot_d;
  logic             div_wrap;
  logic             rise;
  logic             fall;

  // Left-channel capture
  logic [15:0] shift_q, shift_d;
  logic        push_q, push_d;

  // Sample FIFO
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise     = div_wrap && !bclk_q;
  assign fall     = div_wrap && bclk_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d  = div_q + 1'b1;
    bclk_d = bclk_q;
    slot_d = slot_q;
    if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end
    if (fall) begin
      slot_d = slot_q + 6'd1;
    end
  end

  // SD is stable around the BCLK rise because the mic only changes it after
  // the fall; slot 0 is the one-bit I2S delay, slots above 16 are discarded.
  always_comb begin
    shift_d = shift_q;
    push_d  = 1'b0;
    if (rise && (slot_q >= 6'd1) && (slot_q <= 6'd16)) begin
      shift_d = {shift_q[14:0], i2s_sd};
    end
    if (rise && (slot_q == 6'd16)) begin
      push_d = 1'b1;
    end
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = sample_ack && valid_q;
  assign do_push = push_q && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A push into a full FIFO is dropped unless the consumer frees a slot now.
    if (push_q && full && !do_pop) begin
      ovf_d = 1'b1;
    end
    valid_d = (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      slot_q   <= '0;
      shift_q  <= '0;
      push_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      push_q   <= push_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the sample storage is not reset; the pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = slot_q[5];
  assign audio_valid = valid_q;
  assign overflow    = ovf_q;
  assign pcm_out     = valid_q ? mem_q[rd_ptr_q] : 16'h0000;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Self-checking bench for i2s_mic_rx: a cycle-indexed reference model of the
// I2S frame timing and sample FIFO, driven with random and directed traffic.
module tb_i2s_mic_rx;

  localparam int CLK_DIV   = 4;
  localparam int DEPTH     = 4;
  localparam int SLOT_CYC  = 2 * CLK_DIV;
  localparam int FRAME_CYC = 64 * SLOT_CYC;
  // Slot k is sampled at cycle CLK_DIV + k*SLOT_CYC; the push lands one cycle after slot 16.
  localparam int PUSH_OFS  = CLK_DIV + 16 * SLOT_CYC + 1;

  logic        clk;
  logic        reset;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sd;
  logic [15:0] pcm_out;
  logic        audio_valid;
  logic        sample_ack;
  logic        overflow;

  i2s_mic_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sd      (i2s_sd),
    .pcm_out     (pcm_out),
    .audio_valid (audio_valid),
    .sample_ack  (sample_ack),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] left_w  [16];
  logic [15:0] right_w [16];
  logic [15:0] mdl_q [$];
  logic        mdl_ovf;
  int          cyc;
  int          n_checks;
  int          n_fail;

  function automatic logic [15:0] mdl_head();
    return (mdl_q.size() != 0) ? mdl_q[0] : 16'h0000;
  endfunction

  task automatic randomize_words();
    for (int i = 0; i < 16; i++) begin
      left_w[i]  = 16'($urandom);
      right_w[i] = 16'($urandom);
    end
  endtask

  // Microphone: a new bit appears at the start of each slot (just after BCLK falls).
  task automatic drive_sd();
    int s;
    int f;
    s = (cyc / SLOT_CYC) % 64;
    f = (cyc / FRAME_CYC) % 16;
    if (cyc % SLOT_CYC == 0) begin
      if (s >= 1 && s <= 16)       i2s_sd = left_w[f][16 - s];
      else if (s >= 33 && s <= 48) i2s_sd = right_w[f][48 - s];
      else                         i2s_sd = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    sample_ack = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    mdl_q.delete();
    mdl_ovf = 1'b0;
    cyc     = 0;
    reset   = 1'b0;
    drive_sd();
  endtask

  // Advance one clk with the given ack and update the reference model.
  task automatic step(input logic ack);
    logic        pop;
    logic        push;
    logic [15:0] tmp;
    int          f;
    sample_ack = ack;
    pop = ack && (mdl_q.size() != 0);
    @(posedge clk);
    #1;
    cyc++;
    push = (cyc >= PUSH_OFS) && ((cyc - PUSH_OFS) % FRAME_CYC == 0);
    if (pop) tmp = mdl_q.pop_front();
    if (push) begin
      f = ((cyc - PUSH_OFS) / FRAME_CYC) % 16;
      if (mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
      else mdl_q.push_back(left_w[f]);
    end
    drive_sd();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    sample_ack = 1'b1;
    i2s_sd     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (i2s_bclk !== 1'b0) begin n_fail++; $display("FAIL reset_bclk got %b want 0", i2s_bclk); end
    n_checks++;
    if (i2s_lrclk !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk got %b want 0", i2s_lrclk); end
    n_checks++;
    if (audio_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", audio_valid); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++;
    if (pcm_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pcm got %h want 0000", pcm_out); end
  endtask

  task automatic test_clock_outputs();
    logic exp_b;
    logic exp_l;
    logic prev_b;
    logic prev_l;
    int   first_rise;
    int   last_rise;
    int   last_lr_rise;
    randomize_words();
    do_reset(2);
    prev_b = 1'b0; prev_l = 1'b0;
    first_rise = -1; last_rise = -1; last_lr_rise = -1;
    for (int i = 0; i < 1100; i++) begin
      step(1'b0);
      exp_b = 1'((cyc / CLK_DIV) % 2);
      exp_l = 1'((cyc / (32 * SLOT_CYC)) % 2);
      n_checks++;
      if (i2s_bclk !== exp_b || i2s_lrclk !== exp_l) begin
        n_fail++;
        $display("FAIL clk_wave cyc=%0d bclk=%b want %b lrclk=%b want %b", cyc, i2s_bclk, exp_b, i2s_lrclk, exp_l);
      end
      if (i2s_lrclk !== prev_l) begin
        n_checks++;
        if (!(prev_b == 1'b1 && i2s_bclk == 1'b0)) begin
          n_fail++;
          $display("FAIL lrclk_edge cyc=%0d lrclk moved without bclk fall (bclk %b->%b)", cyc, prev_b, i2s_bclk);
        end
        if (i2s_lrclk == 1'b1) begin
          if (last_lr_rise >= 0) begin
            n_checks++;
            if (cyc - last_lr_rise != 2 * FRAME_CYC / 2) begin
              n_fail++;
              $display("FAIL lrclk_period got %0d want %0d", cyc - last_lr_rise, FRAME_CYC);
            end
          end
          last_lr_rise = cyc;
        end
      end
      if (prev_b == 1'b0 && i2s_bclk == 1'b1) begin
        if (first_rise < 0) first_rise = cyc;
        if (last_rise >= 0) begin
          n_checks++;
          if (cyc - last_rise != SLOT_CYC) begin
            n_fail++;
            $display("FAIL bclk_period cyc=%0d got %0d want %0d", cyc, cyc - last_rise, SLOT_CYC);
          end
        end
        last_rise = cyc;
      end
      prev_b = i2s_bclk;
      prev_l = i2s_lrclk;
    end
    n_checks++;
    if (first_rise != CLK_DIV) begin
      n_fail++;
      $display("FAIL first_rise got %0d want %0d", first_rise, CLK_DIV);
    end
  endtask

  task automatic test_single_frame();
    randomize_words();
    left_w[0]  = 16'hA5C3;
    right_w[0] = 16'hFFFF;
    do_reset(2);
    while (cyc < 140) begin
      step(cyc == 133);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL single_frame cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
      if (cyc == 132) begin
        n_checks++;
        if (audio_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cyc=132 got %b want 0", audio_valid); end
      end
      if (cyc == 133) begin
        n_checks++;
        if (audio_valid !== 1'b1 || pcm_out !== 16'hA5C3) begin
          n_fail++;
          $display("FAIL first_sample cyc=133 valid=%b pcm=%h want 1 a5c3", audio_valid, pcm_out);
        end
      end
      if (cyc == 134) begin
        n_checks++;
        if (audio_valid !== 1'b0) begin n_fail++; $display("FAIL ack_drop cyc=134 got %b want 0", audio_valid); end
      end
    end
  endtask

  task automatic test_fifo_fill();
    randomize_words();
    for (int i = 0; i < 5; i++) left_w[i] = 16'(i + 1);
    do_reset(2);
    while (cyc < 4 * FRAME_CYC + PUSH_OFS) begin
      step(1'b0);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL fifo_fill cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
      if (cyc == 3 * FRAME_CYC + PUSH_OFS + 1) begin
        n_checks++;
        if (overflow !== 1'b0 || pcm_out !== 16'h0001) begin
          n_fail++;
          $display("FAIL four_held ovf=%b pcm=%h want 0 0001", overflow, pcm_out);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL fifth_overflow got %b want 1", overflow); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (audio_valid !== 1'b1 || pcm_out !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL drain_order k=%0d valid=%b pcm=%h want 1 %h", k, audio_valid, pcm_out, 16'(k + 1));
      end
      step(1'b1);
    end
    step(1'b0);
    n_checks++;
    if (audio_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drained valid=%b ovf=%b want 0 1", audio_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    randomize_words();
    do_reset(2);
    while (cyc < 4 * FRAME_CYC + PUSH_OFS) begin
      step(cyc == 4 * FRAME_CYC + PUSH_OFS - 1);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL full_pp cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || pcm_out !== left_w[1]) begin
      n_fail++;
      $display("FAIL full_pp_head ovf=%b pcm=%h want 0 %h", overflow, pcm_out, left_w[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (audio_valid !== 1'b1 || pcm_out !== left_w[k]) begin
        n_fail++;
        $display("FAIL full_pp_drain k=%0d valid=%b pcm=%h want 1 %h", k, audio_valid, pcm_out, left_w[k]);
      end
      step(1'b1);
    end
    sample_ack = 1'b0;
    n_checks++;
    if (audio_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pp_end valid=%b ovf=%b want 0 0", audio_valid, overflow);
    end
  endtask

  task automatic test_spurious_ack();
    randomize_words();
    do_reset(2);
    while (cyc < FRAME_CYC + PUSH_OFS) begin
      step(cyc < 134);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL spurious cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
      if (cyc == 133) begin
        n_checks++;
        if (audio_valid !== 1'b1 || pcm_out !== left_w[0]) begin
          n_fail++;
          $display("FAIL push_with_ack valid=%b pcm=%h want 1 %h", audio_valid, pcm_out, left_w[0]);
        end
      end
    end
    n_checks++;
    if (audio_valid !== 1'b1 || pcm_out !== left_w[1]) begin
      n_fail++;
      $display("FAIL after_spurious valid=%b pcm=%h want 1 %h", audio_valid, pcm_out, left_w[1]);
    end
  endtask

  task automatic test_midframe_reset();
    randomize_words();
    do_reset(2);
    while (cyc < FRAME_CYC + 9 * SLOT_CYC + 3) step(1'b0);
    n_checks++;
    if (audio_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", audio_valid); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (audio_valid !== 1'b0 || overflow !== 1'b0 || pcm_out !== 16'h0000 || i2s_bclk !== 1'b0 || i2s_lrclk !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs valid=%b ovf=%b pcm=%h bclk=%b lrclk=%b want all 0",
               audio_valid, overflow, pcm_out, i2s_bclk, i2s_lrclk);
    end
    randomize_words();
    do_reset(2);
    while (cyc < PUSH_OFS + 4) begin
      step(1'b0);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL midreset cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
    end
    n_checks++;
    if (audio_valid !== 1'b1 || pcm_out !== left_w[0] || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_first valid=%b pcm=%h ovf=%b want 1 %h 0", audio_valid, pcm_out, overflow, left_w[0]);
    end
  endtask

  task automatic test_random_traffic();
    int thr;
    randomize_words();
    do_reset(2);
    thr = 0;
    while (cyc < 7 * FRAME_CYC) begin
      if (cyc % FRAME_CYC == 0) begin
        case ($urandom_range(0, 2))
          0:       thr = 0;
          1:       thr = 3;
          default: thr = 400;
        endcase
      end
      step($urandom_range(0, 999) < thr);
      n_checks++;
      if (audio_valid !== (mdl_q.size() != 0) || pcm_out !== mdl_head() || overflow !== mdl_ovf) begin
        n_fail++;
        $display("FAIL random cyc=%0d valid=%b/%b pcm=%h/%h ovf=%b/%b", cyc, audio_valid,
                 (mdl_q.size() != 0), pcm_out, mdl_head(), overflow, mdl_ovf);
      end
    end
    sample_ack = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    mdl_ovf    = 1'b0;
    reset      = 1'b1;
    sample_ack = 1'b0;
    i2s_sd     = 1'b0;
    test_reset();
    test_clock_outputs();
    test_single_frame();
    test_fifo_fill();
    test_full_push_pop();
    test_spurious_ack();
    test_midframe_reset();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal range is 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of sample buffer entries; power of two, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i2s_bclk, output, 1 bit: registered I2S bit clock driven to the microphone.
REQ-006 SHALL have port i2s_lrclk, output, 1 bit: registered I2S word select; 0 = left channel.
REQ-007 SHALL have port i2s_sd, input, 1 bit: serial data from the microphone, which changes after falling BCLK.
REQ-008 SHALL have port pcm_out, output, 16 bits: the FIFO head sample, two's complement.
REQ-009 SHALL have port audio_valid, output, 1 bit: high when the FIFO is not empty.
REQ-010 SHALL have port sample_ack, input, 1 bit: the consumer pops the head sample.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.

Function
REQ-012 SHALL generate BCLK from a divider counting 0..CLK_DIV-1; i2s_bclk toggles in the cycle after the count reaches CLK_DIV-1, and the count then wraps to 0.
REQ-013 SHALL keep a 6-bit slot counter that increments on every BCLK falling toggle, wrapping 63 to 0; i2s_lrclk equals slot[5] and is updated together with the falling toggle.
REQ-014 SHALL define a "rise event" as the clk cycle in which i2s_bclk is registered from 0 to 1.
REQ-015 SHALL sample i2s_sd at each rise event directly, with no synchronizer, because BCLK is derived from clk.
REQ-016 SHALL shift the left channel into a 16-bit register MSB first during slots 1..16; slot 0 is the I2S one-bit delay.
REQ-017 SHALL ignore all bits in slots 17..63, including the right channel and the microphone's low-order bits beyond bit 16.
REQ-018 SHALL issue a push to the FIFO on the clk edge following the slot-16 rise event, carrying the 16 captured bits: slot-1 bit to [15], slot-16 bit to [0].
REQ-019 SHALL store at most one sample per 64-slot frame.
REQ-020 SHALL implement the FIFO as a circular buffer with read and write pointers plus a count (or an extra pointer bit), distinguishing full from empty.
REQ-021 SHALL drive pcm_out from the head entry and hold it stable while audio_valid is 1 until a pop occurs.
REQ-022 SHALL drive audio_valid from a register, so that it rises exactly 1 clk after a push into an empty FIFO.
REQ-023 SHALL perform a pop when sample_ack=1 and audio_valid=1; the next entry, or audio_valid=0, appears on the following clk.
REQ-024 SHALL ignore sample_ack while audio_valid=0.
REQ-025 SHALL, on a push while the FIFO is full with no pop in the same cycle, discard the new sample, leave stored data unchanged and set overflow to 1.
REQ-026 SHALL, on a simultaneous push and pop while full, pop the head, accept the push and leave overflow unchanged.
REQ-027 SHALL, on a simultaneous push and pop while empty, accept the push and ignore the pop; audio_valid becomes 1.
REQ-028 SHALL, on a simultaneous push and pop with 0 < count < FIFO_DEPTH, keep the count unchanged.
REQ-029 SHALL clear overflow only by reset.
REQ-030 SHALL keep the BCLK frequency at clk/(2*CLK_DIV) and the frame length at 128*CLK_DIV clk cycles.

Reset
REQ-031 SHALL, while reset=1 at a clk edge, clear the divider, slot counter, shift register, FIFO pointers and count.
REQ-032 SHALL, while reset=1, drive i2s_bclk=0, i2s_lrclk=0, audio_valid=0, overflow=0 and pcm_out=16'h0000.
REQ-033 SHALL, when reset is asserted mid-frame, abandon any partial capture and never push it.
REQ-034 SHALL, after reset is released, start the frame again at slot 0; with CLK_DIV=4 the first rise event is at cycle 4 after release.
REQ-035 SHALL, when reset is asserted mid-frame, discard all FIFO contents; the first push after release occurs in the first full frame.

Verification
REQ-036 SHALL cover single frame: CLK_DIV=4, left word 16'hA5C3 in slots 1..16, right word 16'hFFFF -> pcm_out=16'hA5C3, audio_valid rises at cycle 133 after reset release, then ack drops audio_valid on the next clk.
REQ-037 SHALL cover clock outputs: i2s_bclk period 8 clk; i2s_lrclk period 512 clk; lrclk changes only on cycles where bclk falls.
REQ-038 SHALL cover FIFO fill: 4 frames with words 0x0001..0x0004 and no ack -> all held, overflow=0; a 5th frame with 0x0005 -> overflow=1; 4 acks return 0x0001..0x0004 in order.
REQ-039 SHALL cover full with push and pop: ack held high in the push cycle while full -> the head is popped, the new word is stored and overflow stays 0.
REQ-040 SHALL cover spurious ack: sample_ack=1 while empty -> no pointer change; the next frame's word is presented correctly.
REQ-041 SHALL cover mid-frame reset: reset asserted during slot 9 -> no push from that frame; the first sample comes from the next full frame; overflow=0.
